// File: rtl/cache_pkg.sv
// Shared line-cache CPU-side port types, imported by every client of the cache.
package CACHE;

    typedef enum logic [0:0] {
        READ  = 1'b0,
        WRITE = 1'b1
    } cmd_t;

endpackage

// File: rtl/fetch_queue_pkg.sv
// Constants and helpers shared by the fetch queue and its byte FIFO.
package fetch_queue_pkg;

    // Decoder window width in bytes; fixed by the decoder interface.
    localparam int unsigned WIN = 16;

    // Fetch FSM encodings.
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    // Limit a retire length to what the window actually holds.
    function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] avail);
        return (len > avail) ? avail : len;
    endfunction

endpackage

// File: rtl/fetch_bytefifo.sv
// Circular byte buffer: 8-byte write port with leading-byte skip, 16-byte read window,
// variable-length pop. Pointers carry one extra bit so full and empty differ.
module fetch_bytefifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned QBYTES = 32,
    localparam int unsigned PW    = $clog2(QBYTES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [63:0]      wr_data,
    input  logic [2:0]       skip,
    input  logic             pop_en,
    input  logic [4:0]       pop_len,
    output logic [WIN*8-1:0] win_bytes,
    output logic [4:0]       win_count,
    output logic [PW-1:0]    used
);

    localparam int unsigned AW = PW - 1;

    logic [7:0]    mem_q [QBYTES];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;

    // Occupancy and the read window, decoded purely from registered state.
    always_comb begin
        used      = tail_q - head_q;
        win_count = (used >= PW'(WIN)) ? 5'(WIN) : 5'(used);
        win_bytes = '0;
        for (int i = 0; i < int'(WIN); i++) begin
            if (5'(i) < win_count) begin
                win_bytes[8*i +: 8] = mem_q[head_q[AW-1:0] + AW'(i)];
            end
        end
    end

    // Pointer and storage update; enqueue and pop may coincide, flush overrides both.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            mem_q  <= '{default: 8'h00};
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (wr_en) begin
                // Bytes below skip precede the fetch target and are dropped.
                for (int i = 0; i < 8; i++) begin
                    if (3'(i) >= skip) begin
                        mem_q[tail_q[AW-1:0] + AW'(i) - AW'(skip)] <= wr_data[8*i +: 8];
                    end
                end
                tail_q <= tail_q + PW'(4'd8 - {1'b0, skip});
            end
            if (pop_en) begin
                head_q <= head_q + PW'(pop_len);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues aligned 8-byte reads to the line cache, buffers the
// returned bytes and presents a 16-byte window to the decoder. Redirects flush and refetch.
module fetch_queue
    import CACHE::*;
    import fetch_queue_pkg::*;
#(
    parameter int unsigned QBYTES   = 32,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [63:0]      redirect_pc,
    output logic             reqcyc,
    output cmd_t             cmd,
    output logic [63:0]      req_addr,
    output logic [63:0]      req_data,
    input  logic             respcyc,
    input  logic [63:0]      resp_data,
    output logic [WIN*8-1:0] out_bytes,
    output logic [4:0]       out_count,
    output logic [63:0]      out_pc,
    input  logic             consume,
    input  logic [4:0]       consume_len
);

    localparam int unsigned PW = $clog2(QBYTES) + 1;

    logic [1:0]    state_q, state_d;
    logic [63:0]   fetch_addr_q, fetch_addr_d;
    logic [2:0]    skip_q, skip_d;
    logic [63:0]   req_addr_q, req_addr_d;
    logic [63:0]   out_pc_q, out_pc_d;

    logic [PW-1:0] used;
    logic [4:0]    win_count;
    logic          has_room;
    logic          accept;
    logic          pop_en;
    logic [4:0]    pop_len;

    // Only one request is ever outstanding, so occupancy alone decides whether 8 bytes fit.
    assign has_room = (used <= PW'(QBYTES - 8));
    assign accept   = (state_q == StWait) && respcyc && !redirect;
    assign pop_en   = consume && !redirect;
    assign pop_len  = clamp_len(consume_len, win_count);

    fetch_bytefifo #(
        .QBYTES (QBYTES)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .wr_en     (accept),
        .wr_data   (resp_data),
        .skip      (skip_q),
        .pop_en    (pop_en),
        .pop_len   (pop_len),
        .win_bytes (out_bytes),
        .win_count (win_count),
        .used      (used)
    );

    // Fetch FSM and PC bookkeeping; a redirect overrides everything else this cycle.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        req_addr_d   = req_addr_q;
        out_pc_d     = out_pc_q;

        case (state_q)
            StIdle: begin
                if (has_room) begin
                    state_d    = StWait;
                    req_addr_d = fetch_addr_q;
                end
            end
            StWait: begin
                if (respcyc) begin
                    state_d      = StIdle;
                    fetch_addr_d = fetch_addr_q + 64'd8;
                    skip_d       = 3'd0;
                end
            end
            StDrain: begin
                if (respcyc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop_en) begin
            out_pc_d = out_pc_q + 64'(pop_len);
        end

        if (redirect) begin
            out_pc_d     = redirect_pc;
            fetch_addr_d = {redirect_pc[63:3], 3'b000};
            skip_d       = redirect_pc[2:0];
            if (state_q == StIdle) begin
                // Queue is empty after the flush, so the new request can go out at once.
                state_d    = StWait;
                req_addr_d = {redirect_pc[63:3], 3'b000};
            end else begin
                // A request is in flight: swallow its response unless it lands right now.
                state_d = respcyc ? StIdle : StDrain;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            fetch_addr_q <= {RESET_PC[63:3], 3'b000};
            skip_q       <= RESET_PC[2:0];
            req_addr_q   <= 64'h0;
            out_pc_q     <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            req_addr_q   <= req_addr_d;
            out_pc_q     <= out_pc_d;
        end
    end

    assign reqcyc    = (state_q != StIdle);
    assign cmd       = READ;
    assign req_addr  = req_addr_q;
    assign req_data  = 64'h0;
    assign out_count = win_count;
    assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue: the bench plays the line cache, and a byte scoreboard
// tracks the expected fetch stream, window contents and PC.
module tb_fetch_queue;

    logic         clk;
    logic         reset;
    logic         redirect;
    logic [63:0]  redirect_pc;
    logic         reqcyc;
    CACHE::cmd_t  cmd;
    logic [63:0]  req_addr;
    logic [63:0]  req_data;
    logic         respcyc;
    logic [63:0]  resp_data;
    logic [127:0] out_bytes;
    logic [4:0]   out_count;
    logic [63:0]  out_pc;
    logic         consume;
    logic [4:0]   consume_len;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected byte stream, PC of its head and the next expected fetch address.
    logic [7:0]  exp_q[$];
    logic [63:0] exp_pc;
    logic [63:0] exp_fetch;
    logic [63:0] drain_addr;
    int          sb_skip;
    bit          sb_drop;

    fetch_queue #(
        .QBYTES   (32),
        .RESET_PC (64'h1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .reqcyc      (reqcyc),
        .cmd         (cmd),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .respcyc     (respcyc),
        .resp_data   (resp_data),
        .out_bytes   (out_bytes),
        .out_count   (out_count),
        .out_pc      (out_pc),
        .consume     (consume),
        .consume_len (consume_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal retire lengths must never be driven.
    always @(posedge clk) begin
        if (reset && consume && (consume_len == 5'd0 || consume_len > out_count)) begin
            $error("consume_len %0d out of range (out_count %0d)", consume_len, out_count);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Cache memory image: the byte at address a is a[7:0].
    function automatic logic [63:0] mk(input logic [63:0] a);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'(a + 64'(i));
        return d;
    endfunction

    function automatic logic [127:0] exp_win();
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) if (j < exp_q.size()) w[8*j +: 8] = exp_q[j];
        return w;
    endfunction

    function automatic logic [4:0] exp_cnt();
        return (exp_q.size() > 16) ? 5'd16 : 5'(exp_q.size());
    endfunction

    // Act as the cache for one request: wait for it, check it, answer after lat cycles,
    // optionally retiring cons bytes in the response cycle.
    task automatic respond(input int lat, input int cons);
        int w;
        logic [63:0] want;
        w = 0;
        while (reqcyc !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (reqcyc !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout reqcyc=%b want=1 after %0d cycles", reqcyc, w);
            return;
        end
        want = sb_drop ? drain_addr : exp_fetch;
        checks++;
        if (req_addr !== want) begin
            failures++;
            $display("FAIL req_addr got=%h want=%h", req_addr, want);
        end
        repeat (lat) begin
            @(negedge clk);
            checks++;
            if (reqcyc !== 1'b1 || req_addr !== want) begin
                failures++;
                $display("FAIL req_hold reqcyc=%b addr=%h want reqcyc=1 addr=%h",
                         reqcyc, req_addr, want);
            end
        end
        respcyc   = 1'b1;
        resp_data = mk(req_addr);
        if (cons > 0) begin
            consume     = 1'b1;
            consume_len = 5'(cons);
            repeat (cons) void'(exp_q.pop_front());
            exp_pc += 64'(cons);
        end
        if (sb_drop) begin
            sb_drop = 1'b0;
        end else begin
            for (int i = sb_skip; i < 8; i++) exp_q.push_back(8'(want + 64'(i)));
            sb_skip = 0;
            exp_fetch += 64'd8;
        end
        @(negedge clk);
        respcyc     = 1'b0;
        resp_data   = '0;
        consume     = 1'b0;
        consume_len = '0;
    endtask

    task automatic drive_redirect(input logic [63:0] pc, input bit in_wait);
        redirect    = 1'b1;
        redirect_pc = pc;
        if (in_wait && !sb_drop) begin
            drain_addr = exp_fetch;
            sb_drop    = 1'b1;
        end
        exp_q.delete();
        exp_pc    = pc;
        exp_fetch = pc & ~64'h7;
        sb_skip   = int'(pc[2:0]);
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic drive_consume(input int n);
        consume     = 1'b1;
        consume_len = 5'(n);
        repeat (n) void'(exp_q.pop_front());
        exp_pc += 64'(n);
        @(negedge clk);
        consume     = 1'b0;
        consume_len = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (reqcyc !== 1'b0) begin failures++; $display("FAIL rst_reqcyc got=%b want=0", reqcyc); end
        checks++; if (cmd !== CACHE::READ) begin failures++; $display("FAIL rst_cmd got=%0d want=%0d", cmd, CACHE::READ); end
        checks++; if (req_addr !== 64'h0) begin failures++; $display("FAIL rst_req_addr got=%h want=0", req_addr); end
        checks++; if (req_data !== 64'h0) begin failures++; $display("FAIL rst_req_data got=%h want=0", req_data); end
        checks++; if (out_count !== 5'd0) begin failures++; $display("FAIL rst_out_count got=%0d want=0", out_count); end
        checks++; if (out_bytes !== 128'h0) begin failures++; $display("FAIL rst_out_bytes got=%h want=0", out_bytes); end
        checks++; if (out_pc !== 64'h1000) begin failures++; $display("FAIL rst_out_pc got=%h want=1000", out_pc); end
        exp_q.delete();
        exp_pc    = 64'h1000;
        exp_fetch = 64'h1000;
        sb_skip   = 0;
        sb_drop   = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic test_first_fetch();
        respond(2, 0);
        checks++; if (out_count !== 5'd8) begin failures++; $display("FAIL first_count got=%0d want=8", out_count); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL first_bytes got=%h want=%h", out_bytes, exp_win()); end
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL first_pc got=%h want=%h", out_pc, exp_pc); end
        checks++; if (reqcyc !== 1'b0) begin failures++; $display("FAIL first_reqcyc_drop got=%b want=0", reqcyc); end
        respond(1, 0);
        checks++; if (out_count !== exp_cnt()) begin failures++; $display("FAIL second_count got=%0d want=%0d", out_count, exp_cnt()); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL second_bytes got=%h want=%h", out_bytes, exp_win()); end
        checks++; if (reqcyc !== 1'b0) begin failures++; $display("FAIL second_reqcyc_drop got=%b want=0", reqcyc); end
    endtask

    task automatic test_redirect_idle();
        drive_redirect(64'h2005, 1'b0);
        checks++; if (out_count !== 5'd0) begin failures++; $display("FAIL rdi_flush_count got=%0d want=0", out_count); end
        checks++; if (out_pc !== 64'h2005) begin failures++; $display("FAIL rdi_flush_pc got=%h want=2005", out_pc); end
        checks++; if (reqcyc !== 1'b1) begin failures++; $display("FAIL rdi_reqcyc got=%b want=1", reqcyc); end
        checks++; if (req_addr !== 64'h2000) begin failures++; $display("FAIL rdi_req_addr got=%h want=2000", req_addr); end
        respond(1, 0);
        checks++; if (out_count !== 5'd3) begin failures++; $display("FAIL rdi_count got=%0d want=3", out_count); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL rdi_bytes got=%h want=%h", out_bytes, exp_win()); end
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL rdi_pc got=%h want=%h", out_pc, exp_pc); end
    endtask

    task automatic test_redirect_wait();
        @(negedge clk);
        checks++; if (reqcyc !== 1'b1) begin failures++; $display("FAIL rdw_pre_reqcyc got=%b want=1", reqcyc); end
        drive_redirect(64'h3003, 1'b1);
        checks++; if (out_count !== 5'd0) begin failures++; $display("FAIL rdw_flush_count got=%0d want=0", out_count); end
        checks++; if (reqcyc !== 1'b1) begin failures++; $display("FAIL rdw_drain_reqcyc got=%b want=1", reqcyc); end
        respond(4, 0);
        checks++; if (out_count !== 5'd0) begin failures++; $display("FAIL rdw_discard_count got=%0d want=0", out_count); end
        checks++; if (out_pc !== 64'h3003) begin failures++; $display("FAIL rdw_pc got=%h want=3003", out_pc); end
        respond(1, 0);
        checks++; if (out_count !== exp_cnt()) begin failures++; $display("FAIL rdw_count got=%0d want=%0d", out_count, exp_cnt()); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL rdw_bytes got=%h want=%h", out_bytes, exp_win()); end
    endtask

    task automatic test_full();
        int highs;
        drive_redirect(64'h4000, 1'b0);
        for (int k = 0; k < 4; k++) respond(0, 0);
        highs = 0;
        repeat (8) begin
            @(negedge clk);
            if (reqcyc === 1'b1) highs++;
        end
        checks++; if (highs != 0) begin failures++; $display("FAIL full_no_request reqcyc_cycles=%0d want=0", highs); end
        checks++; if (out_count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d want=16", out_count); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL full_bytes got=%h want=%h", out_bytes, exp_win()); end
        drive_consume(8);
        checks++; if (out_pc !== 64'h4008) begin failures++; $display("FAIL full_consume_pc got=%h want=4008", out_pc); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL full_consume_bytes got=%h want=%h", out_bytes, exp_win()); end
        respond(1, 0);
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL full_refill_bytes got=%h want=%h", out_bytes, exp_win()); end
    endtask

    task automatic test_back_to_back();
        drive_redirect(64'h5004, 1'b0);
        respond(1, 0);
        respond(1, 0);
        checks++; if (out_count !== 5'd12) begin failures++; $display("FAIL b2b_pre_count got=%0d want=12", out_count); end
        respond(2, 5);
        checks++; if (out_count !== 5'd15) begin failures++; $display("FAIL b2b_count got=%0d want=15", out_count); end
        checks++; if (out_pc !== 64'h5009) begin failures++; $display("FAIL b2b_pc got=%h want=5009", out_pc); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL b2b_bytes got=%h want=%h", out_bytes, exp_win()); end
    endtask

    task automatic test_wrap();
        drive_redirect(64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        respond(1, 0);
        respond(1, 0);
        checks++; if (out_count !== 5'd14) begin failures++; $display("FAIL wrap_count got=%0d want=14", out_count); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL wrap_bytes got=%h want=%h", out_bytes, exp_win()); end
        drive_consume(10);
        checks++; if (out_pc !== 64'h4) begin failures++; $display("FAIL wrap_pc got=%h want=4", out_pc); end
        checks++; if (out_bytes !== exp_win()) begin failures++; $display("FAIL wrap_tail_bytes got=%h want=%h", out_bytes, exp_win()); end
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        respcyc     = 1'b0;
        resp_data   = '0;
        consume     = 1'b0;
        consume_len = '0;
        test_reset();
        test_first_fetch();
        test_redirect_idle();
        test_redirect_wait();
        test_full();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
